// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared word, RAM status and arbiter state types plus the watchdog fill word
// No ports; imported by the arbiter interface, top and watchdog.
package cache_mem_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} arb_state_t;
    localparam word_t BAD_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: cache request channels and RAM port bundled for the arbiter
// slave  : arbiter side (takes iREN/iaddr, dREN/dWEN/daddr/dstore, ramload/ramstate; drives waits, loads, RAM strobes, err)
// master : environment side (caches + RAM model), directions mirrored
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;
    logic iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN, err;
    word_t iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    modport slave(
        input iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
    modport master(
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/cache_mem_arbiter_watchdog.sv
// cache_mem_arbiter_watchdog: counts stalled grant cycles and flags the one that must be force-completed
// CLK/RST : clock, sync active-high reset
// run     : grant cycle with a live request and no ACCESS/ERROR
// clear   : arbiter idle, restart the count
// expire  : this stalled cycle is cycle TIMEOUT of the access
module cache_mem_arbiter_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] wd_cnt;
    always_ff @(posedge CLK)
        wd_cnt <= (RST || clear) ? '0 : run ? wd_cnt + 1'b1 : wd_cnt;
    assign expire = run && wd_cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between I- and D-cache, data first with an instruction starvation cap
// CLK/RST : clock, sync active-high reset
// bus     : cache_mem_arbiter_if.slave -- cache channels in, waits/loads out, RAM strobes out, sticky err out
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT = 64
) (
    input logic CLK,
    input logic RST,
    cache_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    arb_state_t state;
    logic [SW-1:0] starve_cnt;
    logic err_q, gi, gd, dpend, dgo, req, ok, expire, done;
    assign gi = state == IGNT;
    assign gd = state == DGNT;
    assign dpend = bus.dREN || bus.dWEN;
    // data wins unless instruction has already been passed over STARVE_MAX times in a row
    assign dgo = dpend && (!bus.iREN || starve_cnt < SW'(STARVE_MAX));
    assign req = gi ? bus.iREN : gd && dpend;
    assign ok = bus.ramstate == ACCESS || bus.ramstate == ERROR;
    assign done = req && (ok || expire);
    cache_mem_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .CLK(CLK),
        .RST(RST),
        .run(req && !ok),
        .clear(state == IDLE),
        .expire(expire)
    );
    always_ff @(posedge CLK)
        if (RST) begin
            state <= IDLE;
            starve_cnt <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                state <= dgo ? DGNT : bus.iREN ? IGNT : IDLE;
                // dgo with iREN implies starve_cnt < STARVE_MAX, so the increment saturates there
                starve_cnt <= (bus.iREN && dgo) ? starve_cnt + 1'b1 : '0;
            end else if (done || !req)
                state <= IDLE;
            if (done && (bus.ramstate == ERROR || !ok))
                err_q <= 1'b1;
        end
    assign bus.ramREN = gi ? bus.iREN : gd && bus.dREN && !bus.dWEN;
    assign bus.ramWEN = gd && bus.dWEN;
    assign bus.ramaddr = gi ? bus.iaddr : gd ? bus.daddr : '0;
    assign bus.ramstore = gd ? bus.dstore : '0;
    assign bus.iwait = !(gi && done);
    assign bus.dwait = !(gd && done);
    assign bus.iload = (gi && done) ? (ok ? bus.ramload : BAD_WORD) : '0;
    assign bus.dload = (gd && done) ? (ok ? bus.ramload : BAD_WORD) : '0;
    assign bus.err = err_q;
endmodule
